// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES-128/192/256 encryption, one round per clock.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready/data_in  block input handshake, mode selects key size
//   abort                      synchronous cancel, returns to IDLE
//   rk_idx/round_key           round-key store read port (RK_LATENCY 0 or 1)
//   out_valid/out_ready        ciphertext handshake, data_out registered
//   busy                       any state other than IDLE

// One state column through SubBytes, optional MixColumns and AddRoundKey.
// The caller has already applied ShiftRows when it assembled the column.
module aes_round_col (
  input  logic [31:0] col,
  input  logic        mix,
  input  logic [31:0] key,
  output logic [31:0] res
);
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // Table is packed with byte 0 in the top slot, so index with ~x (= 255-x).
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] s [4];
  logic [7:0] m [4];

  always_comb begin
    for (int r = 0; r < 4; r++) s[r] = sb(col[31-8*r -: 8]);
    for (int r = 0; r < 4; r++)
      m[r] = xt(s[r]) ^ xt(s[(r+1)%4]) ^ s[(r+1)%4] ^ s[(r+2)%4] ^ s[(r+3)%4];
    res = (mix ? {m[0], m[1], m[2], m[3]} : {s[0], s[1], s[2], s[3]}) ^ key;
  end
endmodule

module aes_cipher_core #(
  parameter int RK_LATENCY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [1:0]   mode,
  input  logic         abort,
  output logic [3:0]   rk_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int NCOL = 4;

  typedef enum logic [1:0] {IDLE, PREFETCH, RUN, DONE} state_t;

  state_t       st, nst;
  logic [3:0]   rc, nr;
  logic [127:0] blk, rnd, nxt_blk;
  logic [NCOL-1:0][31:0] col_in;
  logic         last;

  assign last = (rc == nr);

  // ShiftRows is pure wiring: row r of column c comes from column (c+r)%4.
  // Byte i of the block sits at bits [127-8i -: 8], i = 4*col + row.
  for (genvar c = 0; c < NCOL; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign col_in[c][31-8*r -: 8] = blk[127-8*(4*((c+r)%NCOL)+r) -: 8];
    end
    aes_round_col u_col (
      .col (col_in[c]),
      .mix (!last),
      .key (round_key[127-32*c -: 32]),
      .res (rnd[127-32*c -: 32])
    );
  end

  assign nxt_blk = (rc == 4'd0) ? (blk ^ round_key) : rnd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nst;
  end

  // Next-state logic; abort wins over every other transition
  always_comb begin
    nst = st;
    if (abort) nst = IDLE;
    else begin
      case (st)
        IDLE:     if (in_valid) nst = (RK_LATENCY == 1) ? PREFETCH : RUN;
        PREFETCH: nst = RUN;
        RUN:      if (last) nst = DONE;
        DONE:     if (out_ready) nst = IDLE;
        default:  nst = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready  = (st == IDLE);
    out_valid = (st == DONE);
    busy      = (st != IDLE);
    rk_idx    = 4'd0;
    if (st == RUN) begin
      if (RK_LATENCY == 1) rk_idx = last ? nr : 4'(rc + 4'd1);  // one ahead, saturating
      else                 rk_idx = rc;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk      <= '0;
      rc       <= '0;
      nr       <= 4'd10;
      data_out <= '0;
    end else begin
      if (st == IDLE && in_valid && !abort) begin
        blk <= data_in;
        rc  <= 4'd0;
        case (mode)
          2'b00:   nr <= 4'd10;
          2'b01:   nr <= 4'd12;
          default: nr <= 4'd14;
        endcase
      end else if (st == RUN && !abort) begin
        blk <= nxt_blk;
        if (last) data_out <= nxt_blk;
        else      rc       <= 4'(rc + 4'd1);
      end
    end
  end
endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: two instances (RK_LATENCY 0 and 1) share the
// stimulus; sel picks which one receives in_valid and which one is observed.
module tb_aes_cipher_core;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, abort = 0, out_ready = 1;
  logic [127:0] data_in = '0;
  logic [1:0] mode = '0;
  bit sel = 0;

  logic ir0, ov0, bz0, ir1, ov1, bz1;
  logic [3:0] ix0, ix1;
  logic [127:0] do0, do1, rk0, rk1;

  logic ob_ready, ob_valid, ob_busy;
  logic [3:0] ob_idx;
  logic [127:0] ob_dout;

  int checks = 0, errors = 0;

  logic [127:0] rk_tab [15];
  logic [7:0] sb_tab [256];

  always #5 clk = ~clk;

  aes_cipher_core #(.RK_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir0),
    .data_in(data_in), .mode(mode), .abort(abort), .rk_idx(ix0), .round_key(rk0),
    .out_valid(ov0), .out_ready(out_ready), .data_out(do0), .busy(bz0));

  aes_cipher_core #(.RK_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir1),
    .data_in(data_in), .mode(mode), .abort(abort), .rk_idx(ix1), .round_key(rk1),
    .out_valid(ov1), .out_ready(out_ready), .data_out(do1), .busy(bz1));

  // Key store models: combinational read and one-cycle registered read
  assign rk0 = rk_tab[ix0];
  always @(posedge clk) rk1 <= rk_tab[ix1];

  assign ob_ready = sel ? ir1 : ir0;
  assign ob_valid = sel ? ov1 : ov0;
  assign ob_busy  = sel ? bz1 : bz0;
  assign ob_idx   = sel ? ix1 : ix0;
  assign ob_dout  = sel ? do1 : do0;

  // ---------------- reference model (FIPS-197 arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse plus affine map, not from a table
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0, b, r;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv; b = inv;
      for (int k = 0; k < 4; k++) begin b = {b[6:0], b[7]}; r ^= b; end
      sb_tab[x] = r ^ 8'h63;
    end
  endtask

  function automatic int nr_of(input logic [1:0] md);
    return (md == 2'b00) ? 10 : (md == 2'b01) ? 12 : 14;
  endfunction

  task automatic set_key(input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rcon = 8'h01;
    int nk = nr - 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t ^= {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4)
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 15; i++)
      rk_tab[i] = (i <= nr) ? {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]} : 128'h0;
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = sb_tab[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd == nr) ? t[4*c+r] :
                     gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03) ^
                     t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int i = 0; i < 16; i++) s[i] ^= rk_tab[rd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block to the selected instance and follow it to DONE.
  task automatic run_block(input bit s, input logic [1:0] md, input logic [127:0] pt,
                           input logic [127:0] exp, input string nm);
    int nr = nr_of(md), cyc = 0, lat = -1, exp_lat;
    int seq [$];
    int want [$];
    sel = s;
    @(negedge clk);
    checks++;
    if (ob_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready before accept got %b want 1", nm, ob_ready); end
    in_valid = 1; data_in = pt; mode = md;
    @(posedge clk); #1;
    in_valid = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (ob_valid === 1'b1) begin lat = cyc; break; end
      seq.push_back(int'(ob_idx));
      data_in = rnd128(); mode = 2'($urandom);  // must be ignored mid-run
      @(posedge clk);
      cyc++;
    end
    exp_lat = nr + 1 + int'(s);
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat); end
    checks++;
    if (ob_dout !== exp) begin errors++; $display("FAIL %s data_out got %h want %h", nm, ob_dout, exp); end
    if (s) begin want.push_back(0); for (int i = 1; i <= nr; i++) want.push_back(i); want.push_back(nr); end
    else for (int i = 0; i <= nr; i++) want.push_back(i);
    checks++;
    if (seq != want) begin errors++; $display("FAIL %s rk_idx sequence got %p want %p", nm, seq, want); end
    if (out_ready) begin
      @(negedge clk);
      checks++;
      if (ob_valid !== 1'b0 || ob_ready !== 1'b1) begin
        errors++; $display("FAIL %s return to idle got valid=%b ready=%b want 0/1", nm, ob_valid, ob_ready);
      end
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    checks++;
    if ({ir0, ov0, bz0, ix0, do0} !== {1'b1, 1'b0, 1'b0, 4'd0, 128'h0} ||
        {ir1, ov1, bz1, ix1, do1} !== {1'b1, 1'b0, 1'b0, 4'd0, 128'h0}) begin
      errors++;
      $display("FAIL %s got r/v/b/i=%b%b%b%h,%b%b%b%h dout0=%h dout1=%h want 1000 and zero", nm,
               ir0, ov0, bz0, ix0, ir1, ov1, bz1, ix1, do0, do1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 chk_reset_vals("reset_state");
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_fips(input bit s);
    set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
    run_block(s, 2'b00, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, s ? "aes128_l1" : "aes128_l0");
    set_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 12);
    run_block(s, 2'b01, 128'h00112233445566778899aabbccddeeff,
              128'hdda97ca4864cdfe06eaf70a0ec0d7191, s ? "aes192_l1" : "aes192_l0");
    set_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
    run_block(s, 2'b10, 128'h00112233445566778899aabbccddeeff,
              128'h8ea2b7ca516745bfeafc49904b496089, s ? "aes256_l1" : "aes256_l0");
    run_block(s, 2'b11, 128'h00112233445566778899aabbccddeeff,
              128'h8ea2b7ca516745bfeafc49904b496089, s ? "aes256m3_l1" : "aes256m3_l0");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [1:0] md = 2'($urandom);
      logic [127:0] pt = rnd128();
      bit s = 1'($urandom);
      set_key({rnd128(), rnd128()}, nr_of(md));
      run_block(s, md, pt, ref_enc(pt, nr_of(md)), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt = rnd128(), held;
    set_key({rnd128(), rnd128()}, 10);
    out_ready = 0;
    run_block(0, 2'b00, pt, ref_enc(pt, 10), "bp_first");
    held = ob_dout;
    in_valid = 1; data_in = rnd128();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ob_valid !== 1'b1 || ob_ready !== 1'b0 || ob_dout !== held) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b r=%b d=%h want 1/0/%h", i, ob_valid, ob_ready, ob_dout, held);
      end
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    checks++;
    if (ob_valid !== 1'b0 || ob_ready !== 1'b1 || ob_busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got v=%b r=%b b=%b want 0/1/0", ob_valid, ob_ready, ob_busy);
    end
    pt = rnd128();
    run_block(0, 2'b00, pt, ref_enc(pt, 10), "bp_second");
  endtask

  task automatic test_abort();
    logic [127:0] pt = rnd128();
    bit seen = 0;
    set_key({rnd128(), rnd128()}, 10);
    sel = 0;
    @(negedge clk); in_valid = 1; data_in = pt; mode = 2'b00;
    @(posedge clk); #1 in_valid = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (ix0 == 4'd5) break; end
    abort = 1;
    @(negedge clk); abort = 0;
    checks++;
    if (bz0 !== 1'b0 || ir0 !== 1'b1) begin errors++; $display("FAIL abort_run got busy=%b ready=%b want 0/1", bz0, ir0); end
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (ov0) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_valid got out_valid=1 want 0"); end
    run_block(0, 2'b00, pt, ref_enc(pt, 10), "after_abort");
    // abort in IDLE blocks the accept
    @(negedge clk); abort = 1; in_valid = 1; data_in = pt;
    @(negedge clk); abort = 0; in_valid = 0;
    checks++;
    if (bz0 !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b want 0", bz0); end
    // abort while stalled in DONE
    out_ready = 0;
    run_block(0, 2'b00, pt, ref_enc(pt, 10), "abort_done_blk");
    abort = 1;
    @(negedge clk); abort = 0; out_ready = 1;
    checks++;
    if (ov0 !== 1'b0 || ir0 !== 1'b1) begin errors++; $display("FAIL abort_done got v=%b r=%b want 0/1", ov0, ir0); end
  endtask

  task automatic test_async_reset();
    logic [127:0] pt = rnd128();
    set_key({rnd128(), rnd128()}, 14);
    sel = 1;
    @(negedge clk); in_valid = 1; data_in = pt; mode = 2'b10;
    @(posedge clk); #1 in_valid = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk); rst_n = 1;
    run_block(1, 2'b10, pt, ref_enc(pt, 14), "after_reset");
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips(0);
    test_fips(1);
    test_random();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
